fetch_pc_unit: RTL and testbench

Instruction-fetch control stage sitting directly upstream of the synchronous instruction memory. Holds the program counter, selects the next PC (sequential, branch, jump), and drives the memory's address and enable inputs. Tracks which PC the memory's registered output belongs to, squashing wrong-path fetches after redirects. Provides halt and single-step control for the debug unit.

---
 rtl/fetch_pc_unit.sv | 129 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Brief    : Program counter, next-PC select and fetch tracking in front of a
//             synchronous instruction memory, with halt and single-step control.
//  Revision : 1.0
// ============================================================================
module fetch_pc_unit #(
    parameter int          ADDR_BITS = 10,
    parameter int          RESET_PC  = 0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADDR_BITS-1:0] branch_target,
    input  logic                 jump,
    input  logic [ADDR_BITS-1:0] jump_target,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic [31:0]          inst_data,
    output logic [ADDR_BITS-1:0] pc_addr,
    output logic                 pc_enable,
    output logic [ADDR_BITS-1:0] inst_pc,
    output logic [ADDR_BITS-1:0] inst_pc_plus1,
    output logic                 inst_valid,
    output logic                 halted,
    output logic [31:0]          fetch_count
);

    localparam logic [ADDR_BITS-1:0] c_reset_pc = ADDR_BITS'(RESET_PC);
    localparam logic [ADDR_BITS-1:0] c_pc_one   = ADDR_BITS'(1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STEP_WAIT  = 2'd1,
        ST_STEP_FETCH = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state;
    state_t                w_state_next;
    logic                  r_init;
    logic [ADDR_BITS-1:0]  r_pc;
    logic [ADDR_BITS-1:0]  w_pc_next;
    logic [ADDR_BITS-1:0]  r_fetch_pc;
    logic                  r_fetch_live;
    logic [31:0]           r_fetch_count;
    logic                  w_fetching;
    logic                  w_halt_hit;
    logic                  w_redirect;

    // The first cycle after reset takes its mode straight from step_mode, so
    // the register itself can use a constant reset value.
    assign w_state    = r_init ? (step_mode ? ST_STEP_WAIT : ST_RUN) : r_state;
    assign w_fetching = (w_state == ST_RUN) || (w_state == ST_STEP_FETCH);
    assign w_halt_hit = r_fetch_live && (inst_data == HALT_WORD);
    assign w_redirect = w_fetching && !w_halt_hit && (jump || branch_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_init  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_init  <= 1'b0;
        end
    end

    always_comb begin
        w_state_next = w_state;
        if (w_halt_hit) begin
            w_state_next = ST_HALTED;
        end else begin
            case (w_state)
                ST_RUN: begin
                    if (step_mode) w_state_next = ST_STEP_WAIT;
                end
                ST_STEP_WAIT: begin
                    if (step)            w_state_next = ST_STEP_FETCH;
                    else if (!step_mode) w_state_next = ST_RUN;
                end
                ST_STEP_FETCH: w_state_next = ST_STEP_WAIT;
                ST_HALTED:     w_state_next = ST_HALTED;
                default:       w_state_next = ST_RUN;
            endcase
        end
    end

    // Halt on the word in flight outranks any redirect or stall this cycle.
    always_comb begin
        w_pc_next = r_pc;
        if (w_fetching && !w_halt_hit) begin
            if (jump)              w_pc_next = jump_target;
            else if (branch_taken) w_pc_next = branch_target;
            else if (!stall)       w_pc_next = r_pc + c_pc_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= c_reset_pc;
            r_fetch_pc    <= c_reset_pc;
            r_fetch_live  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_fetching) begin
                r_fetch_pc <= r_pc;
            end
            r_fetch_live <= w_fetching && !w_redirect;
            if (w_fetching && !stall) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign pc_addr       = r_pc;
    assign pc_enable     = rst_n && w_fetching;
    assign inst_pc       = r_fetch_pc;
    assign inst_pc_plus1 = r_fetch_pc + c_pc_one;
    assign inst_valid    = r_fetch_live;
    assign halted        = (w_state == ST_HALTED);
    assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_pc_unit
//  Brief    : Directed and randomized bench for fetch_pc_unit against a
//             cycle-level behavioural model and a model instruction memory.
//  Revision : 1.0
// ============================================================================
module tb_fetch_pc_unit;

    localparam logic [31:0] c_halt   = 32'hFFFF_FFFF;
    localparam int          c_depth  = 1024;
    localparam int          c_run    = 0;
    localparam int          c_wait   = 1;
    localparam int          c_fetch  = 2;
    localparam int          c_halted = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        jump;
    logic [9:0]  jump_target;
    logic        step_mode;
    logic        step;
    logic [31:0] inst_data;
    logic [9:0]  pc_addr;
    logic        pc_enable;
    logic [9:0]  inst_pc;
    logic [9:0]  inst_pc_plus1;
    logic        inst_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic        rst_n_w;
    logic [3:0]  pc_addr_w;
    logic        pc_enable_w;
    logic [3:0]  inst_pc_w;
    logic [3:0]  inst_pc_plus1_w;
    logic        inst_valid_w;
    logic        halted_w;
    logic [31:0] fetch_count_w;

    logic [31:0] mem [0:c_depth-1];

    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .step_mode(step_mode), .step(step), .inst_data(inst_data),
        .pc_addr(pc_addr), .pc_enable(pc_enable), .inst_pc(inst_pc),
        .inst_pc_plus1(inst_pc_plus1), .inst_valid(inst_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_pc_unit #(.ADDR_BITS(4), .RESET_PC(14)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(4'd0),
        .jump(1'b0), .jump_target(4'd0),
        .step_mode(1'b0), .step(1'b0), .inst_data(32'h0),
        .pc_addr(pc_addr_w), .pc_enable(pc_enable_w), .inst_pc(inst_pc_w),
        .inst_pc_plus1(inst_pc_plus1_w), .inst_valid(inst_valid_w),
        .halted(halted_w), .fetch_count(fetch_count_w)
    );

    // Synchronous instruction memory: returns 0 when not enabled.
    always @(posedge clk) inst_data <= pc_enable ? mem[pc_addr] : 32'h0;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_mode;
    int          m_pc;
    int          m_ipc;
    bit          m_ival;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = step_mode ? c_wait : c_run;
        m_pc   = 0;
        m_ipc  = 0;
        m_ival = 1'b0;
        m_data = 32'h0;
        m_cnt  = 32'h0;
    endtask

    // One rising edge of the reference behaviour, using the inputs at that edge.
    task automatic model_step();
        bit en;
        bit hit;
        int npc;
        en  = (m_mode == c_run) || (m_mode == c_fetch);
        hit = m_ival && (m_data == c_halt);
        npc = m_pc;
        if (en && !hit) begin
            if (jump)              npc = int'(jump_target);
            else if (branch_taken) npc = int'(branch_target);
            else if (!stall)       npc = (m_pc + 1) % c_depth;
        end
        m_data = en ? mem[m_pc] : 32'h0;
        if (en) m_ipc = m_pc;
        m_ival = en && (hit || !(jump || branch_taken));
        if (en && !stall) m_cnt = m_cnt + 32'd1;
        m_pc = npc;
        if (hit) begin
            m_mode = c_halted;
        end else if (m_mode == c_run) begin
            if (step_mode) m_mode = c_wait;
        end else if (m_mode == c_wait) begin
            if (step)            m_mode = c_fetch;
            else if (!step_mode) m_mode = c_run;
        end else if (m_mode == c_fetch) begin
            m_mode = c_wait;
        end
    endtask

    task automatic check_all();
        chk("pc_addr", pc_addr, m_pc);
        chk("pc_enable", pc_enable, (m_mode == c_run) || (m_mode == c_fetch));
        chk("inst_pc", inst_pc, m_ipc);
        chk("inst_pc_plus1", inst_pc_plus1, (m_ipc + 1) % c_depth);
        chk("inst_valid", inst_valid, m_ival);
        chk("halted", halted, m_mode == c_halted);
        chk("fetch_count", fetch_count, m_cnt);
        if (m_ival) chk("inst_data", inst_data, m_data);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_in();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; step = 1'b0;
        branch_target = 10'd0; jump_target = 10'd0;
    endtask

    task automatic do_reset(input bit sm);
        @(negedge clk);
        step_mode = sm;
        rst_n = 1'b0;
        clear_in();
        @(negedge clk);
        model_reset();
        chk("rst_pc_enable", pc_enable, 1'b0);
        chk("rst_pc_addr", pc_addr, 10'd0);
        chk("rst_inst_pc", inst_pc, 10'd0);
        chk("rst_inst_pc_plus1", inst_pc_plus1, 10'd1);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int         n_en;
        logic [31:0] saved_cnt;
        rst_n = 1'b0;
        rst_n_w = 1'b0;
        step_mode = 1'b0;
        clear_in();
        for (int i = 0; i < c_depth; i++) mem[i] = $urandom & 32'h7FFF_FFFF;

        // Sequential fetch from reset
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("seq_pc", pc_addr, k);
            chk("seq_inst_pc", inst_pc, k - 1);
            chk("seq_valid", inst_valid, 1'b1);
        end
        chk("seq_count", fetch_count, 32'd5);

        // Jump with one squashed fetch
        jump = 1'b1; jump_target = 10'h040;
        cycle();
        clear_in();
        chk("jmp_pc", pc_addr, 10'h040);
        chk("jmp_squash", inst_valid, 1'b0);
        cycle();
        chk("jmp_inst_pc", inst_pc, 10'h040);
        chk("jmp_valid", inst_valid, 1'b1);

        // Redirect priority over stall
        jump = 1'b1; branch_taken = 1'b1; stall = 1'b1;
        jump_target = 10'h123; branch_target = 10'h2AA;
        cycle();
        chk("prio_jump", pc_addr, 10'h123);
        jump = 1'b0;
        cycle();
        chk("prio_branch", pc_addr, 10'h2AA);

        // Stall held at address 7
        clear_in();
        jump = 1'b1; jump_target = 10'd7;
        cycle();
        clear_in();
        stall = 1'b1;
        saved_cnt = m_cnt;
        repeat (3) begin
            cycle();
            chk("stall_pc", pc_addr, 10'd7);
            chk("stall_inst_pc", inst_pc, 10'd7);
            chk("stall_data", inst_data, mem[7]);
            chk("stall_valid", inst_valid, 1'b1);
            chk("stall_count", fetch_count, saved_cnt);
        end
        clear_in();

        // Randomized redirects and stalls
        repeat (300) begin
            stall         = ($urandom % 4) == 0;
            jump          = ($urandom % 8) == 0;
            branch_taken  = ($urandom % 8) == 0;
            jump_target   = 10'($urandom);
            branch_target = 10'($urandom);
            cycle();
        end

        // Single-step mode
        do_reset(1'b1);
        n_en = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            cycle();
            n_en += int'(pc_enable);
            step = 1'b0;
            repeat (3) begin
                cycle();
                n_en += int'(pc_enable);
            end
        end
        chk("step_fetches", n_en, 3);
        chk("step_pc", pc_addr, 10'd3);
        step = 1'b1;
        repeat (2) cycle();
        step = 1'b0;
        cycle();
        chk("step_drop_pc", pc_addr, 10'd4);
        step_mode = 1'b0;
        repeat (4) cycle();

        // Halt on HALT_WORD at address 5
        mem[5] = c_halt;
        do_reset(1'b0);
        repeat (6) cycle();
        chk("halt_pre_ipc", inst_pc, 10'd5);
        chk("halt_pre", halted, 1'b0);
        branch_taken = 1'b1; branch_target = 10'h100; step = 1'b1;
        cycle();
        chk("halt_set", halted, 1'b1);
        chk("halt_pc", pc_addr, 10'd6);
        repeat (3) cycle();
        chk("halt_en", pc_enable, 1'b0);
        chk("halt_frozen", pc_addr, 10'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_halted", halted, 1'b0);
        chk("async_en", pc_enable, 1'b0);
        chk("async_pc", pc_addr, 10'd0);
        chk("async_count", fetch_count, 32'd0);
        chk("async_valid", inst_valid, 1'b0);
        mem[5] = 32'h0000_1234;
        do_reset(1'b0);
        repeat (8) cycle();

        // Address wrap on a 4-bit instance
        @(negedge clk);
        chk("wrap_rst_plus1", inst_pc_plus1_w, 4'd15);
        rst_n_w = 1'b1;
        #1;
        chk("wrap_pc0", pc_addr_w, 4'd14);
        @(negedge clk);
        chk("wrap_pc1", pc_addr_w, 4'd15);
        @(negedge clk);
        chk("wrap_pc2", pc_addr_w, 4'd0);
        chk("wrap_inst_pc", inst_pc_w, 4'd15);
        chk("wrap_plus1", inst_pc_plus1_w, 4'd0);
        chk("wrap_valid", inst_valid_w, 1'b1);
        chk("wrap_en", pc_enable_w, 1'b1);
        chk("wrap_halted", halted_w, 1'b0);
        chk("wrap_count", fetch_count_w, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
